// File: rtl/transc_pipe.sv
// Six-stage chroma transform pipeline: luma-knee bypass, LUT mean/scale
// remap with signed scaling, per-channel offset and saturation. All stages advance on ce.
module transc_pipe #(
    parameter int DW         = 8,
    parameter int FRAC       = 8,
    parameter int KL         = 125,
    parameter int KH         = 188,
    parameter int MEAN_KH_CR = 154,
    parameter int MEAN_KH_CB = 108
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic                 in_sel,
    input  logic [DW-1:0]        in_y,
    input  logic [DW-1:0]        in_c,
    output logic [DW-1:0]        lut_y,
    output logic                 lut_sel,
    input  logic [DW-1:0]        lut_mean,
    input  logic [DW+FRAC-1:0]   lut_wscale,
    output logic                 out_valid,
    output logic                 out_sel,
    output logic [DW-1:0]        out_c
);

    localparam int WW  = DW + FRAC;
    localparam int DFW = DW + 1;
    // Product width holds any diff * wscale exactly; sum keeps the same width so
    // adding the offset can never overflow.
    localparam int PFW = DFW + WW + 1;

    localparam logic [DW-1:0] KL_V   = DW'(KL);
    localparam logic [DW-1:0] KH_V   = DW'(KH);
    localparam logic [DW-1:0] OFF_CR = DW'(MEAN_KH_CR);
    localparam logic [DW-1:0] OFF_CB = DW'(MEAN_KH_CB);

    // stage 0
    logic                  s0_valid_q, s0_valid_d;
    logic                  s0_sel_q, s0_sel_d;
    logic [DW-1:0]         s0_y_q, s0_y_d;
    logic [DW-1:0]         s0_c_q, s0_c_d;
    // stage 1
    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_sel_q, s1_sel_d;
    logic [DW-1:0]         s1_c_q, s1_c_d;
    logic                  s1_byp_q, s1_byp_d;
    logic [DW-1:0]         s1_mean_q, s1_mean_d;
    logic [WW-1:0]         s1_ws_q, s1_ws_d;
    // stage 2
    logic                  s2_valid_q, s2_valid_d;
    logic                  s2_sel_q, s2_sel_d;
    logic [DW-1:0]         s2_c_q, s2_c_d;
    logic                  s2_byp_q, s2_byp_d;
    logic signed [DFW-1:0] s2_diff_q, s2_diff_d;
    logic [WW-1:0]         s2_ws_q, s2_ws_d;
    // stage 3
    logic                  s3_valid_q, s3_valid_d;
    logic                  s3_sel_q, s3_sel_d;
    logic [DW-1:0]         s3_c_q, s3_c_d;
    logic                  s3_byp_q, s3_byp_d;
    logic signed [PFW-1:0] s3_prod_q, s3_prod_d;
    // stage 4
    logic                  s4_valid_q, s4_valid_d;
    logic                  s4_sel_q, s4_sel_d;
    logic [DW-1:0]         s4_c_q, s4_c_d;
    logic                  s4_byp_q, s4_byp_d;
    logic signed [PFW-1:0] s4_sum_q, s4_sum_d;
    // stage 5 (output)
    logic                  out_valid_q, out_valid_d;
    logic                  out_sel_q, out_sel_d;
    logic [DW-1:0]         out_c_q, out_c_d;

    logic signed [PFW-1:0] diff_ext;
    logic signed [PFW-1:0] ws_ext;
    logic signed [PFW-1:0] prod_full;
    logic signed [PFW-1:0] off_ext;
    logic [DW-1:0]         sat_c;

    assign lut_y     = s0_y_q;
    assign lut_sel   = s0_sel_q;
    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;
    assign out_c     = out_c_q;

    always_comb begin
        diff_ext  = {{(PFW-DFW){s2_diff_q[DFW-1]}}, s2_diff_q};
        ws_ext    = {{(PFW-WW){1'b0}}, s2_ws_q};
        prod_full = diff_ext * ws_ext;
        off_ext   = {{(PFW-DW){1'b0}}, (s3_sel_q ? OFF_CB : OFF_CR)};

        if (s4_sum_q[PFW-1]) begin
            sat_c = '0;
        end else if (|s4_sum_q[PFW-2:DW]) begin
            sat_c = '1;
        end else begin
            sat_c = s4_sum_q[DW-1:0];
        end
    end

    always_comb begin
        s0_valid_d  = s0_valid_q;
        s0_sel_d    = s0_sel_q;
        s0_y_d      = s0_y_q;
        s0_c_d      = s0_c_q;
        s1_valid_d  = s1_valid_q;
        s1_sel_d    = s1_sel_q;
        s1_c_d      = s1_c_q;
        s1_byp_d    = s1_byp_q;
        s1_mean_d   = s1_mean_q;
        s1_ws_d     = s1_ws_q;
        s2_valid_d  = s2_valid_q;
        s2_sel_d    = s2_sel_q;
        s2_c_d      = s2_c_q;
        s2_byp_d    = s2_byp_q;
        s2_diff_d   = s2_diff_q;
        s2_ws_d     = s2_ws_q;
        s3_valid_d  = s3_valid_q;
        s3_sel_d    = s3_sel_q;
        s3_c_d      = s3_c_q;
        s3_byp_d    = s3_byp_q;
        s3_prod_d   = s3_prod_q;
        s4_valid_d  = s4_valid_q;
        s4_sel_d    = s4_sel_q;
        s4_c_d      = s4_c_q;
        s4_byp_d    = s4_byp_q;
        s4_sum_d    = s4_sum_q;
        out_valid_d = out_valid_q;
        out_sel_d   = out_sel_q;
        out_c_d     = out_c_q;

        if (ce) begin
            s0_valid_d  = in_valid;
            s0_sel_d    = in_sel;
            s0_y_d      = in_y;
            s0_c_d      = in_c;

            s1_valid_d  = s0_valid_q;
            s1_sel_d    = s0_sel_q;
            s1_c_d      = s0_c_q;
            s1_byp_d    = (s0_y_q >= KL_V) && (s0_y_q <= KH_V);
            s1_mean_d   = lut_mean;
            s1_ws_d     = lut_wscale;

            s2_valid_d  = s1_valid_q;
            s2_sel_d    = s1_sel_q;
            s2_c_d      = s1_c_q;
            s2_byp_d    = s1_byp_q;
            s2_diff_d   = $signed({1'b0, s1_c_q}) - $signed({1'b0, s1_mean_q});
            s2_ws_d     = s1_ws_q;

            // Arithmetic shift of a signed value floors toward negative infinity.
            s3_valid_d  = s2_valid_q;
            s3_sel_d    = s2_sel_q;
            s3_c_d      = s2_c_q;
            s3_byp_d    = s2_byp_q;
            s3_prod_d   = prod_full >>> FRAC;

            s4_valid_d  = s3_valid_q;
            s4_sel_d    = s3_sel_q;
            s4_c_d      = s3_c_q;
            s4_byp_d    = s3_byp_q;
            s4_sum_d    = s3_prod_q + off_ext;

            out_valid_d = s4_valid_q;
            out_sel_d   = s4_sel_q;
            out_c_d     = s4_byp_q ? s4_c_q : sat_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q  <= 1'b0;
            s0_sel_q    <= 1'b0;
            s0_y_q      <= '0;
            s0_c_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_sel_q    <= 1'b0;
            s1_c_q      <= '0;
            s1_byp_q    <= 1'b0;
            s1_mean_q   <= '0;
            s1_ws_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_sel_q    <= 1'b0;
            s2_c_q      <= '0;
            s2_byp_q    <= 1'b0;
            s2_diff_q   <= '0;
            s2_ws_q     <= '0;
            s3_valid_q  <= 1'b0;
            s3_sel_q    <= 1'b0;
            s3_c_q      <= '0;
            s3_byp_q    <= 1'b0;
            s3_prod_q   <= '0;
            s4_valid_q  <= 1'b0;
            s4_sel_q    <= 1'b0;
            s4_c_q      <= '0;
            s4_byp_q    <= 1'b0;
            s4_sum_q    <= '0;
            out_valid_q <= 1'b0;
            out_sel_q   <= 1'b0;
            out_c_q     <= '0;
        end else begin
            s0_valid_q  <= s0_valid_d;
            s0_sel_q    <= s0_sel_d;
            s0_y_q      <= s0_y_d;
            s0_c_q      <= s0_c_d;
            s1_valid_q  <= s1_valid_d;
            s1_sel_q    <= s1_sel_d;
            s1_c_q      <= s1_c_d;
            s1_byp_q    <= s1_byp_d;
            s1_mean_q   <= s1_mean_d;
            s1_ws_q     <= s1_ws_d;
            s2_valid_q  <= s2_valid_d;
            s2_sel_q    <= s2_sel_d;
            s2_c_q      <= s2_c_d;
            s2_byp_q    <= s2_byp_d;
            s2_diff_q   <= s2_diff_d;
            s2_ws_q     <= s2_ws_d;
            s3_valid_q  <= s3_valid_d;
            s3_sel_q    <= s3_sel_d;
            s3_c_q      <= s3_c_d;
            s3_byp_q    <= s3_byp_d;
            s3_prod_q   <= s3_prod_d;
            s4_valid_q  <= s4_valid_d;
            s4_sel_q    <= s4_sel_d;
            s4_c_q      <= s4_c_d;
            s4_byp_q    <= s4_byp_d;
            s4_sum_q    <= s4_sum_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            out_c_q     <= out_c_d;
        end
    end

endmodule

// File: tb/tb_transc_pipe.sv
// Bench for transc_pipe: directed cases plus randomized traffic against a
// sample-history reference model (output = input from 5 enabled edges earlier).
module tb_transc_pipe;

    logic        clk = 1'b0;
    logic        rst, ce, in_valid, in_sel;
    logic [7:0]  in_y, in_c, lut_y, lut_mean, out_c;
    logic        lut_sel, out_valid, out_sel;
    logic [15:0] lut_wscale;

    logic [7:0]  mean_tab [2][256];
    logic [15:0] ws_tab   [2][256];

    typedef struct {
        bit v;
        bit s;
        int c;
    } rec_t;

    rec_t hist[$];
    bit   exp_v, exp_s;
    int   exp_c;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    assign lut_mean   = mean_tab[lut_sel][lut_y];
    assign lut_wscale = ws_tab[lut_sel][lut_y];

    transc_pipe dut (
        .clk(clk), .rst(rst), .ce(ce),
        .in_valid(in_valid), .in_sel(in_sel), .in_y(in_y), .in_c(in_c),
        .lut_y(lut_y), .lut_sel(lut_sel),
        .lut_mean(lut_mean), .lut_wscale(lut_wscale),
        .out_valid(out_valid), .out_sel(out_sel), .out_c(out_c)
    );

    function automatic int ref_c(int y, int c, int s, int m, int w);
        longint p, q;
        int r;
        if (y >= 125 && y <= 188) return c;
        p = longint'(c - m) * longint'(w);
        q = p / 256;
        if (p < 0 && (p % 256) != 0) q = q - 1;
        q = q + (s != 0 ? 108 : 154);
        if (q < 0) r = 0;
        else if (q > 255) r = 255;
        else r = int'(q);
        return r;
    endfunction

    // Applies one cycle of inputs, advances the reference model, samples #1 after the edge.
    task automatic drive(input bit v, input bit s, input int y, input int c,
                         input bit ce_i, input bit rst_i);
        rec_t r;
        in_valid = v; in_sel = s; in_y = 8'(y); in_c = 8'(c); ce = ce_i; rst = rst_i;
        @(posedge clk);
        if (rst_i) begin
            hist.delete();
            exp_v = 0; exp_s = 0; exp_c = 0;
        end else if (ce_i) begin
            r.v = v;
            r.s = s;
            r.c = ref_c(y, c, int'(s), int'(mean_tab[s][y]), int'(ws_tab[s][y]));
            hist.push_back(r);
            if (hist.size() >= 6) begin
                exp_v = hist[0].v; exp_s = hist[0].s; exp_c = hist[0].c;
                void'(hist.pop_front());
            end else begin
                exp_v = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1, 1, 200, 77, k[0], 1);
            n_cmp++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", out_valid); end
            n_cmp++;
            if (out_c !== 8'd0) begin n_err++; $display("FAIL reset_c got %0d want 0", out_c); end
            n_cmp++;
            if (out_sel !== 1'b0) begin n_err++; $display("FAIL reset_sel got %0b want 0", out_sel); end
        end
    endtask

    task automatic test_bypass();
        int ys[4] = '{150, 125, 188, 189};
        int cs[4] = '{200, 33, 44, 60};
        int want[3] = '{200, 33, 44};
        for (int k = 0; k < 10; k++) begin
            if (k < 4) drive(1, 0, ys[k], cs[k], 1, 0);
            else       drive(0, 0, 0, 0, 1, 0);
            n_cmp++;
            if (out_valid !== exp_v) begin n_err++; $display("FAIL bypass_valid k=%0d got %0b want %0b", k, out_valid, exp_v); end
            if (exp_v) begin
                n_cmp++;
                if (out_c !== 8'(exp_c)) begin n_err++; $display("FAIL bypass_c k=%0d got %0d want %0d", k, out_c, exp_c); end
            end
            if (k >= 5 && k <= 7) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_c !== 8'(want[k-5]))
                    begin n_err++; $display("FAIL bypass_direct k=%0d got v=%0b c=%0d want v=1 c=%0d", k, out_valid, out_c, want[k-5]); end
            end
        end
    endtask

    task automatic test_transform();
        int want[3] = '{169, 255, 0};
        mean_tab[0][50] = 8'd150; ws_tab[0][50] = 16'h0180;
        mean_tab[0][20] = 8'd100; ws_tab[0][20] = 16'h0300;
        mean_tab[1][30] = 8'd200; ws_tab[1][30] = 16'h0200;
        for (int k = 0; k < 9; k++) begin
            case (k)
                0: drive(1, 0, 50, 160, 1, 0);
                1: drive(1, 0, 20, 255, 1, 0);
                2: drive(1, 1, 30, 0, 1, 0);
                default: drive(0, 0, 0, 0, 1, 0);
            endcase
            n_cmp++;
            if (out_valid !== exp_v) begin n_err++; $display("FAIL xform_valid k=%0d got %0b want %0b", k, out_valid, exp_v); end
            if (k >= 5 && k <= 7) begin
                n_cmp++;
                if (out_c !== 8'(want[k-5])) begin n_err++; $display("FAIL xform_c k=%0d got %0d want %0d", k, out_c, want[k-5]); end
                n_cmp++;
                if (out_sel !== (k == 7)) begin n_err++; $display("FAIL xform_sel k=%0d got %0b want %0b", k, out_sel, (k == 7)); end
            end
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 24; k++) begin
            if (k < 16) drive(1, 1'($urandom), $urandom_range(0, 255), $urandom_range(0, 255),
                              !(k >= 7 && k <= 9), 0);
            else        drive(0, 0, 0, 0, 1, 0);
            n_cmp++;
            if (out_valid !== exp_v) begin n_err++; $display("FAIL stall_valid k=%0d got %0b want %0b", k, out_valid, exp_v); end
            if (exp_v) begin
                n_cmp++;
                if (out_sel !== exp_s) begin n_err++; $display("FAIL stall_sel k=%0d got %0b want %0b", k, out_sel, exp_s); end
                n_cmp++;
                if (out_c !== 8'(exp_c)) begin n_err++; $display("FAIL stall_c k=%0d got %0d want %0d", k, out_c, exp_c); end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) drive(1, 1'(k), 10 + k, 100 + k, 1, 0);
        drive(0, 0, 0, 0, 1, 1);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %0b want 0", out_valid); end
        n_cmp++;
        if (out_c !== 8'd0) begin n_err++; $display("FAIL rstmid_c got %0d want 0", out_c); end
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 0, 0, 1, 0);
            n_cmp++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_stale k=%0d got %0b want 0", k, out_valid); end
        end
    endtask

    task automatic test_interleave();
        for (int k = 0; k < 26; k++) begin
            if (k < 20) drive(1'($urandom), 1'(k), $urandom_range(0, 255), $urandom_range(0, 255), 1, 0);
            else        drive(0, 0, 0, 0, 1, 0);
            n_cmp++;
            if (out_valid !== exp_v) begin n_err++; $display("FAIL ilv_valid k=%0d got %0b want %0b", k, out_valid, exp_v); end
            if (exp_v) begin
                n_cmp++;
                if (out_sel !== exp_s) begin n_err++; $display("FAIL ilv_sel k=%0d got %0b want %0b", k, out_sel, exp_s); end
                n_cmp++;
                if (out_c !== 8'(exp_c)) begin n_err++; $display("FAIL ilv_c k=%0d got %0d want %0d", k, out_c, exp_c); end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 406; k++) begin
            if (k < 400) drive(1'($urandom), 1'($urandom), $urandom_range(0, 255), $urandom_range(0, 255),
                               ($urandom % 5) != 0, ($urandom % 97) == 0);
            else         drive(0, 0, 0, 0, 1, 0);
            n_cmp++;
            if (out_valid !== exp_v) begin n_err++; $display("FAIL rand_valid k=%0d got %0b want %0b", k, out_valid, exp_v); end
            if (exp_v) begin
                n_cmp++;
                if (out_sel !== exp_s) begin n_err++; $display("FAIL rand_sel k=%0d got %0b want %0b", k, out_sel, exp_s); end
                n_cmp++;
                if (out_c !== 8'(exp_c)) begin n_err++; $display("FAIL rand_c k=%0d got %0d want %0d", k, out_c, exp_c); end
            end
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 256; a++) begin
                mean_tab[s][a] = 8'($urandom_range(0, 255));
                ws_tab[s][a]   = 16'($urandom_range(0, 65535));
            end
        exp_v = 0; exp_s = 0; exp_c = 0;
        test_reset();
        test_bypass();
        test_transform();
        test_stall();
        test_reset_mid();
        test_interleave();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
